// File: rtl/prefetch_sequencer.sv
// Instruction-prefetch controller: issues single-dword code reads while the
// prefetch FIFO has room, writes length-tagged dwords into the FIFO and posts
// limit / page-fault markers when fetching has to stop.
module prefetch_sequencer #(
    parameter int unsigned USED_MAX = 14
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        pr_reset,
    input  logic [31:0] pr_address,
    input  logic [31:0] pr_limit,

    input  logic [4:0]  prefetchfifo_used,

    output logic        req_do,
    output logic [31:0] req_address,
    input  logic        resp_done,
    input  logic [31:0] resp_data,
    input  logic        resp_pf_fault,

    output logic        prefetchfifo_write_do,
    output logic [35:0] prefetchfifo_write_data,
    output logic        prefetchfifo_signal_limit_do,
    output logic        prefetchfifo_signal_pf_do
);

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        IDLE  = 2'd1,
        BUSY  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [31:0] addr, addr_n;
    logic [31:0] remain, remain_n;
    logic [31:0] req_address_q, req_address_n;

    logic        write_q, write_n;
    logic        limit_q, limit_n;
    logic        pf_q, pf_n;
    logic [35:0] wdata_q, wdata_n;

    logic        room;
    logic [1:0]  off;
    logic [3:0]  avail;
    logic [3:0]  len;
    logic [31:0] shifted;
    logic [31:0] masked;

    assign room  = {27'd0, prefetchfifo_used} < USED_MAX;
    assign off   = addr[1:0];
    assign avail = 4'd4 - {2'b00, off};

    // Bytes delivered by this response: up to the dword end, clipped by the budget.
    always_comb begin
        if (remain < {28'd0, avail}) begin
            len = remain[3:0];
        end else begin
            len = avail;
        end
        shifted = resp_data >> {off, 3'b000};
        masked  = shifted;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i >= 32'(len)) begin
                masked[8*i +: 8] = '0;
            end
        end
    end

    // Next-state and next-register logic; pr_reset overrides every state.
    always_comb begin
        state_n       = state;
        addr_n        = addr;
        remain_n      = remain;
        req_address_n = req_address_q;
        write_n       = 1'b0;
        limit_n       = 1'b0;
        pf_n          = 1'b0;
        wdata_n       = wdata_q;

        if (pr_reset) begin
            addr_n   = pr_address;
            remain_n = pr_limit;
            // A read still on the bus must be waited out so its data is dropped.
            if ((state == BUSY || state == DRAIN) && !resp_done) begin
                state_n = DRAIN;
            end else begin
                state_n = IDLE;
            end
        end else begin
            case (state)
                HALT: begin
                    state_n = HALT;
                end
                IDLE: begin
                    if (room) begin
                        if (remain == '0) begin
                            limit_n = 1'b1;
                            state_n = HALT;
                        end else begin
                            req_address_n = {addr[31:2], 2'b00};
                            state_n       = BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (resp_done) begin
                        if (resp_pf_fault) begin
                            pf_n    = 1'b1;
                            state_n = HALT;
                        end else begin
                            write_n  = 1'b1;
                            wdata_n  = {len, masked};
                            addr_n   = addr + {28'd0, len};
                            remain_n = remain - {28'd0, len};
                            state_n  = IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (resp_done) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = HALT;
                end
            endcase
        end
    end

    // State, fetch pointer and registered FIFO strobe stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= HALT;
            addr          <= '0;
            remain        <= '0;
            req_address_q <= '0;
            write_q       <= 1'b0;
            limit_q       <= 1'b0;
            pf_q          <= 1'b0;
            wdata_q       <= '0;
        end else begin
            state         <= state_n;
            addr          <= addr_n;
            remain        <= remain_n;
            req_address_q <= req_address_n;
            write_q       <= write_n;
            limit_q       <= limit_n;
            pf_q          <= pf_n;
            wdata_q       <= wdata_n;
        end
    end

    assign req_do                       = (state == BUSY);
    assign req_address                  = req_address_q;
    assign prefetchfifo_write_data      = wdata_q;
    // Strobes are masked while the FIFO is being cleared by pr_reset.
    assign prefetchfifo_write_do        = write_q & ~pr_reset;
    assign prefetchfifo_signal_limit_do = limit_q & ~pr_reset;
    assign prefetchfifo_signal_pf_do    = pf_q    & ~pr_reset;

endmodule

// File: tb/tb_prefetch_sequencer.sv
// Directed bench for prefetch_sequencer with hand-computed expectations.
module tb_prefetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pr_reset;
    logic [31:0] pr_address;
    logic [31:0] pr_limit;
    logic [4:0]  prefetchfifo_used;
    logic        req_do;
    logic [31:0] req_address;
    logic        resp_done;
    logic [31:0] resp_data;
    logic        resp_pf_fault;
    logic        prefetchfifo_write_do;
    logic [35:0] prefetchfifo_write_data;
    logic        prefetchfifo_signal_limit_do;
    logic        prefetchfifo_signal_pf_do;

    int total = 0;
    int bad   = 0;

    prefetch_sequencer #(.USED_MAX(14)) dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .pr_reset                     (pr_reset),
        .pr_address                   (pr_address),
        .pr_limit                     (pr_limit),
        .prefetchfifo_used            (prefetchfifo_used),
        .req_do                       (req_do),
        .req_address                  (req_address),
        .resp_done                    (resp_done),
        .resp_data                    (resp_data),
        .resp_pf_fault                (resp_pf_fault),
        .prefetchfifo_write_do        (prefetchfifo_write_do),
        .prefetchfifo_write_data      (prefetchfifo_write_data),
        .prefetchfifo_signal_limit_do (prefetchfifo_signal_limit_do),
        .prefetchfifo_signal_pf_do    (prefetchfifo_signal_pf_do)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle, apply that cycle's inputs, let them settle.
    task automatic drv(input logic pr, input logic [31:0] a, input logic [31:0] l,
                       input logic [4:0] u, input logic rd, input logic [31:0] d,
                       input logic pf);
        @(posedge clk);
        #1;
        pr_reset          = pr;
        pr_address        = a;
        pr_limit          = l;
        prefetchfifo_used = u;
        resp_done         = rd;
        resp_data         = d;
        resp_pf_fault     = pf;
        #1;
    endtask

    task automatic idle_cyc(input logic [4:0] u);
        drv(1'b0, 32'h0, 32'h0, u, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_do"}, {63'd0, req_do}, 64'd0);
        chk({tag, "_req_addr"}, {32'd0, req_address}, 64'd0);
        chk({tag, "_wr"}, {63'd0, prefetchfifo_write_do}, 64'd0);
        chk({tag, "_wdata"}, {28'd0, prefetchfifo_write_data}, 64'd0);
        chk({tag, "_lim"}, {63'd0, prefetchfifo_signal_limit_do}, 64'd0);
        chk({tag, "_pf"}, {63'd0, prefetchfifo_signal_pf_do}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        pr_reset = 1'b0; pr_address = '0; pr_limit = '0; prefetchfifo_used = '0;
        resp_done = 1'b0; resp_data = '0; resp_pf_fault = 1'b0;
        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;
        idle_cyc(5'd0);
        idle_cyc(5'd0);
        chk("halt_after_reset_req", {63'd0, req_do}, 64'd0);

        // Limit reached: start 0x1002, 7 bytes -> 2 + 4 + 1 then limit marker.
        drv(1'b1, 32'h0000_1002, 32'd7, 5'd0, 1'b0, 32'h0, 1'b0);
        chk("lim_prreset_req", {63'd0, req_do}, 64'd0);
        idle_cyc(5'd0);
        chk("lim_idle_req", {63'd0, req_do}, 64'd0);
        idle_cyc(5'd0);
        chk("lim_rd1_req", {63'd0, req_do}, 64'd1);
        chk("lim_rd1_addr", {32'd0, req_address}, 64'h1000);
        drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 32'hBBAA_1234, 1'b0);
        chk("lim_rd1_hold", {63'd0, req_do}, 64'd1);
        idle_cyc(5'd0);
        chk("lim_wr1_do", {63'd0, prefetchfifo_write_do}, 64'd1);
        chk("lim_wr1_data", {28'd0, prefetchfifo_write_data}, 64'h2_0000_BBAA);
        chk("lim_wr1_req_low", {63'd0, req_do}, 64'd0);
        idle_cyc(5'd0);
        chk("lim_wr1_one_cycle", {63'd0, prefetchfifo_write_do}, 64'd0);
        chk("lim_rd2_req", {63'd0, req_do}, 64'd1);
        chk("lim_rd2_addr", {32'd0, req_address}, 64'h1004);
        drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 32'h4433_2211, 1'b0);
        idle_cyc(5'd0);
        chk("lim_wr2_do", {63'd0, prefetchfifo_write_do}, 64'd1);
        chk("lim_wr2_data", {28'd0, prefetchfifo_write_data}, 64'h4_4433_2211);
        idle_cyc(5'd0);
        chk("lim_rd3_addr", {32'd0, req_address}, 64'h1008);
        chk("lim_rd3_req", {63'd0, req_do}, 64'd1);
        drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 32'hAABB_CCDD, 1'b0);
        idle_cyc(5'd0);
        chk("lim_wr3_do", {63'd0, prefetchfifo_write_do}, 64'd1);
        chk("lim_wr3_data", {28'd0, prefetchfifo_write_data}, 64'h1_0000_00DD);
        chk("lim_wr3_no_lim", {63'd0, prefetchfifo_signal_limit_do}, 64'd0);
        idle_cyc(5'd0);
        chk("lim_marker", {63'd0, prefetchfifo_signal_limit_do}, 64'd1);
        chk("lim_marker_no_wr", {63'd0, prefetchfifo_write_do}, 64'd0);
        chk("lim_marker_req", {63'd0, req_do}, 64'd0);
        idle_cyc(5'd0);
        chk("lim_marker_one_cycle", {63'd0, prefetchfifo_signal_limit_do}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle_cyc(5'd0);
            chk("lim_halt_req", {63'd0, req_do}, 64'd0);
        end

        // Back-pressure: used=14 holds off, dropping to 13 issues next cycle.
        drv(1'b1, 32'h0000_3000, 32'd100, 5'd14, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle_cyc(5'd14);
            chk("bp_hold_req", {63'd0, req_do}, 64'd0);
        end
        idle_cyc(5'd13);
        chk("bp_decide_req", {63'd0, req_do}, 64'd0);
        idle_cyc(5'd13);
        chk("bp_issue_req", {63'd0, req_do}, 64'd1);
        chk("bp_issue_addr", {32'd0, req_address}, 64'h3000);

        // Page fault on the outstanding read.
        drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 32'h1234_5678, 1'b1);
        idle_cyc(5'd0);
        chk("pf_marker", {63'd0, prefetchfifo_signal_pf_do}, 64'd1);
        chk("pf_no_wr", {63'd0, prefetchfifo_write_do}, 64'd0);
        chk("pf_req", {63'd0, req_do}, 64'd0);
        idle_cyc(5'd0);
        chk("pf_one_cycle", {63'd0, prefetchfifo_signal_pf_do}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle_cyc(5'd0);
            chk("pf_halt_req", {63'd0, req_do}, 64'd0);
        end

        // Flush mid-read: stale 0xDEADBEEF response must be swallowed.
        drv(1'b1, 32'h0000_5001, 32'd100, 5'd0, 1'b0, 32'h0, 1'b0);
        idle_cyc(5'd0);
        idle_cyc(5'd0);
        chk("fl_busy_req", {63'd0, req_do}, 64'd1);
        chk("fl_busy_addr", {32'd0, req_address}, 64'h5000);
        drv(1'b1, 32'h0000_2000, 32'd16, 5'd0, 1'b0, 32'h0, 1'b0);
        idle_cyc(5'd0);
        chk("fl_drain_req1", {63'd0, req_do}, 64'd0);
        idle_cyc(5'd0);
        chk("fl_drain_req2", {63'd0, req_do}, 64'd0);
        drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        chk("fl_drain_req3", {63'd0, req_do}, 64'd0);
        idle_cyc(5'd0);
        chk("fl_no_wr", {63'd0, prefetchfifo_write_do}, 64'd0);
        chk("fl_idle_req", {63'd0, req_do}, 64'd0);
        idle_cyc(5'd0);
        chk("fl_new_req", {63'd0, req_do}, 64'd1);
        chk("fl_new_addr", {32'd0, req_address}, 64'h2000);

        // pr_reset coinciding with resp_done: go straight to IDLE.
        drv(1'b1, 32'h0000_6000, 32'd16, 5'd0, 1'b1, 32'h1111_1111, 1'b0);
        idle_cyc(5'd0);
        chk("sim_no_wr", {63'd0, prefetchfifo_write_do}, 64'd0);
        chk("sim_idle_req", {63'd0, req_do}, 64'd0);
        idle_cyc(5'd0);
        chk("sim_req", {63'd0, req_do}, 64'd1);
        chk("sim_addr", {32'd0, req_address}, 64'h6000);

        // pr_reset in the cycle of a pending write strobe suppresses it.
        drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 32'h8765_4321, 1'b0);
        drv(1'b1, 32'hFFFF_FFFE, 32'd8, 5'd0, 1'b0, 32'h0, 1'b0);
        chk("sup_wr_gated", {63'd0, prefetchfifo_write_do}, 64'd0);

        // Address wrap from 0xFFFF_FFFE.
        idle_cyc(5'd0);
        idle_cyc(5'd0);
        chk("wrap_req", {63'd0, req_do}, 64'd1);
        chk("wrap_addr", {32'd0, req_address}, 64'hFFFF_FFFC);
        drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 32'hCAFE_F00D, 1'b0);
        idle_cyc(5'd0);
        chk("wrap_wr_do", {63'd0, prefetchfifo_write_do}, 64'd1);
        chk("wrap_wr_data", {28'd0, prefetchfifo_write_data}, 64'h2_0000_CAFE);
        idle_cyc(5'd0);
        chk("wrap_next_req", {63'd0, req_do}, 64'd1);
        chk("wrap_next_addr", {32'd0, req_address}, 64'h0);

        // Asynchronous reset while BUSY.
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle_cyc(5'd0);
            chk("arst_halt_req", {63'd0, req_do}, 64'd0);
        end
        drv(1'b1, 32'h0000_7000, 32'd4, 5'd0, 1'b0, 32'h0, 1'b0);
        idle_cyc(5'd0);
        idle_cyc(5'd0);
        chk("arst_restart_req", {63'd0, req_do}, 64'd1);
        chk("arst_restart_addr", {32'd0, req_address}, 64'h7000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
